// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared constants for the load/store unit and its helpers:
//   - OP_ENUM_TYPE with the OP_LB..OP_SW operation codes
//   - ADDR_TYPE / DATA_TYPE word types
//   - LSU state encodings (LSU_IDLE, LSU_ACCESS, LSU_DONE)
//   - accessSize()   : bytes touched by an operation (1, 2 or 4)
//   - isMisaligned() : natural-alignment test used by the optional trap
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_OP_WIDTH   = 6;

  typedef logic [LSU_ADDR_WIDTH-1:0] ADDR_TYPE;
  typedef logic [LSU_DATA_WIDTH-1:0] DATA_TYPE;

  typedef enum logic [LSU_OP_WIDTH-1:0] {
    OP_NONE = 6'd0,
    OP_LB   = 6'd1,
    OP_LH   = 6'd2,
    OP_LW   = 6'd3,
    OP_LBU  = 6'd4,
    OP_LHU  = 6'd5,
    OP_SB   = 6'd6,
    OP_SH   = 6'd7,
    OP_SW   = 6'd8
  } OP_ENUM_TYPE;

  // State encodings kept as plain constants so older modules can share them.
  localparam logic [1:0] LSU_IDLE   = 2'd0;
  localparam logic [1:0] LSU_ACCESS = 2'd1;
  localparam logic [1:0] LSU_DONE   = 2'd2;

  // Number of bytes moved over the 8-bit memory port for an operation.
  function automatic logic [2:0] accessSize(input logic [LSU_OP_WIDTH-1:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd1;
    endcase
  endfunction

  // Halfwords need an even address, words a multiple of four.
  function automatic logic isMisaligned(input logic [2:0] size,
                                        input logic [1:0] addrLow);
    return ((size == 3'd2) && addrLow[0]) ||
           ((size == 3'd4) && (addrLow != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational sign/zero extension of an assembled load value.
// Ports:
//   i_value  : raw little-endian assembled bytes (unused upper lanes are 0)
//   i_op     : operation code (OP_LB/LH sign-extend, OP_LBU/LHU zero-extend,
//              anything else passes i_value through unchanged)
//   o_result : extended load result
// DATA_WIDTH is expected to be at least 32.
// ---------------------------------------------------------------------------
module load_extend
  import load_store_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) (
  input  logic [DATA_WIDTH-1:0] i_value,
  input  logic [OP_WIDTH-1:0]   i_op,
  output logic [DATA_WIDTH-1:0] o_result
);

  // Byte and halfword loads take only the low lanes; the rest of the word is
  // filled from the top bit of the loaded item or with zeros.
  always_comb begin
    o_result = i_value;
    case (i_op)
      OP_LB:  o_result = {{(DATA_WIDTH-8){i_value[7]}}, i_value[7:0]};
      OP_LBU: o_result = {{(DATA_WIDTH-8){1'b0}}, i_value[7:0]};
      OP_LH:  o_result = {{(DATA_WIDTH-16){i_value[15]}}, i_value[15:0]};
      OP_LHU: o_result = {{(DATA_WIDTH-16){1'b0}}, i_value[15:0]};
      default: o_result = i_value;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Executes one load or store at a time from the load/store buffer, moving the
// data byte-serially over the shared 8-bit memory port.
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned LH/LHU/SH/LW/SW skip memory traffic, finish the
//                cycle after acceptance and raise misalign_to_lsb with the end
//                pulse (data 0)
//   undefined -> misaligned accesses simply proceed byte by byte
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low freezes all state)
//   LSB request : enable_from_lsb, read_write_flag_from_lsb (1=store),
//                 op_enum_from_lsb, object_address_from_lsb, data_from_lsb
//   LSB result  : busy_to_lsb, end_to_lsb (1-cycle pulse), data_to_lsb
//   ROB         : roll_back_flag_from_rob (kills in-flight loads only)
//   Memory      : mem_req_out, mem_gnt_in (same cycle), mem_a_out,
//                 mem_dout_out, mem_wr_out, mem_din_in (cycle after a granted
//                 read)
//   misalign_to_lsb : only present with LSU_MISALIGN_TRAP_EN
// DATA_WIDTH is expected to be 32 (four byte lanes).
// ---------------------------------------------------------------------------
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 6
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  enable_from_lsb,
  input  logic                  read_write_flag_from_lsb,
  input  logic [OP_WIDTH-1:0]   op_enum_from_lsb,
  input  logic [ADDR_WIDTH-1:0] object_address_from_lsb,
  input  logic [DATA_WIDTH-1:0] data_from_lsb,
  output logic                  busy_to_lsb,
  output logic                  end_to_lsb,
  output logic [DATA_WIDTH-1:0] data_to_lsb,
  input  logic                  roll_back_flag_from_rob,
  output logic                  mem_req_out,
  input  logic                  mem_gnt_in,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic [7:0]            mem_dout_out,
  output logic                  mem_wr_out,
  input  logic [7:0]            mem_din_in
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_to_lsb
`endif
);

  logic [1:0]            r_state;
  logic [OP_WIDTH-1:0]   r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_storeData;
  logic [2:0]            r_size;
  logic [2:0]            r_k;
  logic                  r_isLoad;
  logic                  r_pendValid;
  logic [1:0]            r_pendLane;
  logic [DATA_WIDTH-1:0] r_assembled;
  logic                  r_misalign;

  logic                  w_issue;
  logic                  w_granted;
  logic                  w_lastIssue;
  logic                  w_lastCapture;
  logic                  w_accept;
  logic [2:0]            w_reqSize;
  logic                  w_trap;
  logic [DATA_WIDTH-1:0] w_extended;

  // A byte goes out while in ACCESS with bytes left to issue. Once a load has
  // issued every byte it just waits for the final capture without requesting.
  assign w_issue   = rdy_in && (r_state == LSU_ACCESS) && (r_k < r_size);
  assign w_granted = w_issue && mem_gnt_in;

  assign w_lastIssue   = (r_k == (r_size - 3'd1));
  assign w_lastCapture = r_pendValid && ({1'b0, r_pendLane} == (r_size - 3'd1));

  // A load arriving together with a flush belongs to the squashed path, so it
  // is dropped; stores are already committed and are always taken.
  assign w_accept  = enable_from_lsb &&
                     !(roll_back_flag_from_rob && !read_write_flag_from_lsb);
  assign w_reqSize = accessSize(op_enum_from_lsb);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = isMisaligned(w_reqSize, object_address_from_lsb[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // Memory port: address walks upward from the latched base and wraps
  // naturally at the top of the address space.
  assign mem_req_out  = w_issue;
  assign mem_a_out    = w_issue ? (r_addr + ADDR_WIDTH'(r_k)) : '0;
  assign mem_dout_out = (w_issue && !r_isLoad) ?
                        r_storeData[{r_k[1:0], 3'b000} +: 8] : 8'h00;
  assign mem_wr_out   = w_granted && !r_isLoad;

  // Result side is decoded from the registered state.
  assign busy_to_lsb = (r_state != LSU_IDLE);
  assign end_to_lsb  = (r_state == LSU_DONE);
  assign data_to_lsb = (end_to_lsb && r_isLoad && !r_misalign) ? w_extended : '0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_to_lsb = end_to_lsb && r_misalign;
`endif

  load_extend #(
    .DATA_WIDTH (DATA_WIDTH),
    .OP_WIDTH   (OP_WIDTH)
  ) u_loadExtend (
    .i_value  (r_assembled),
    .i_op     (r_op),
    .o_result (w_extended)
  );

  // Main sequencer. IDLE latches a request, ACCESS issues bytes and collects
  // load data one cycle behind each granted read, DONE emits the end pulse.
  // With rdy_in low nothing here moves.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= LSU_IDLE;
      r_op        <= '0;
      r_addr      <= '0;
      r_storeData <= '0;
      r_size      <= 3'd0;
      r_k         <= 3'd0;
      r_isLoad    <= 1'b0;
      r_pendValid <= 1'b0;
      r_pendLane  <= 2'd0;
      r_assembled <= '0;
      r_misalign  <= 1'b0;
    end else if (rdy_in) begin
      case (r_state)
        LSU_IDLE: begin
          r_pendValid <= 1'b0;
          if (w_accept) begin
            r_op        <= op_enum_from_lsb;
            r_addr      <= object_address_from_lsb;
            r_storeData <= data_from_lsb;
            r_size      <= w_reqSize;
            r_isLoad    <= !read_write_flag_from_lsb;
            r_k         <= 3'd0;
            r_assembled <= '0;
            r_misalign  <= w_trap;
            r_state     <= w_trap ? LSU_DONE : LSU_ACCESS;
          end
        end

        LSU_ACCESS: begin
          // The byte returned now belongs to the read granted last cycle,
          // independent of what the arbiter does this cycle.
          if (r_pendValid) begin
            r_assembled[{r_pendLane, 3'b000} +: 8] <= mem_din_in;
          end
          r_pendValid <= r_isLoad && w_granted;
          r_pendLane  <= r_k[1:0];
          if (w_granted) begin
            r_k <= r_k + 3'd1;
          end

          if (roll_back_flag_from_rob && r_isLoad) begin
            r_state     <= LSU_IDLE;
            r_pendValid <= 1'b0;
          end else if (!r_isLoad && w_granted && w_lastIssue) begin
            r_state <= LSU_DONE;
          end else if (r_isLoad && w_lastCapture) begin
            r_state <= LSU_DONE;
          end
        end

        LSU_DONE: begin
          r_state <= LSU_IDLE;
        end

        default: begin
          r_state <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule
